// File: rtl/prf_bypass.sv
// Multi-port physical register file with per-entry ready scoreboard bits,
// same-cycle write->read bypass and an optional hardwired zero entry.
module prf_bypass #(
   parameter int unsigned  ENTRY_WIDTH   = 32,
   parameter int unsigned  N_ENTRIES     = 64,
   parameter int unsigned  N_READ_PORTS  = 4,
   parameter int unsigned  N_WRITE_PORTS = 2,
   parameter int unsigned  N_ALLOC_PORTS = 2,
   parameter bit           ZERO_REG      = 1'b1,
   parameter bit           BYPASS        = 1'b1,
   localparam int unsigned PTR_WIDTH     = $clog2(N_ENTRIES)
) (
   input  logic                                      clk,
   input  logic                                      rst_aL,
   input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr,
   output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data,
   output logic [N_READ_PORTS-1:0]                   rd_ready,
   input  logic [N_WRITE_PORTS-1:0]                  wr_en,
   input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr,
   input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
   input  logic [N_ALLOC_PORTS-1:0]                  alloc_en,
   input  logic [N_ALLOC_PORTS-1:0][PTR_WIDTH-1:0]   alloc_addr,
   output logic [PTR_WIDTH:0]                        n_not_ready
);

   logic [ENTRY_WIDTH-1:0] r_data [N_ENTRIES];
   logic [N_ENTRIES-1:0]   r_ready;
   logic [PTR_WIDTH:0]     r_n_not_ready;

   logic [ENTRY_WIDTH-1:0] w_data_d [N_ENTRIES];
   logic [N_ENTRIES-1:0]   w_ready_d;
   logic [PTR_WIDTH:0]     w_n_not_ready_d;

   function automatic logic is_zero(input logic [PTR_WIDTH-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   always_comb begin
      w_data_d  = r_data;
      w_ready_d = r_ready;
      // Descending so the lowest-index writer is applied last and wins.
      for (int i = int'(N_WRITE_PORTS) - 1; i >= 0; i--) begin
         if (wr_en[i] && !is_zero(wr_addr[i])) begin
            w_data_d[wr_addr[i]]  = wr_data[i];
            w_ready_d[wr_addr[i]] = 1'b1;
         end
      end
      // Allocation after writes: a same-cycle alloc leaves the entry not ready.
      for (int k = 0; k < int'(N_ALLOC_PORTS); k++) begin
         if (alloc_en[k] && !is_zero(alloc_addr[k])) begin
            w_ready_d[alloc_addr[k]] = 1'b0;
         end
      end
   end

   always_comb begin
      w_n_not_ready_d = '0;
      for (int e = 0; e < int'(N_ENTRIES); e++) begin
         w_n_not_ready_d = w_n_not_ready_d + (PTR_WIDTH+1)'(!w_ready_d[e]);
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         for (int e = 0; e < int'(N_ENTRIES); e++) begin
            r_data[e] <= '0;
         end
         r_ready       <= '1;
         r_n_not_ready <= '0;
      end else begin
         r_data        <= w_data_d;
         r_ready       <= w_ready_d;
         r_n_not_ready <= w_n_not_ready_d;
      end
   end

   always_comb begin
      rd_data  = '0;
      rd_ready = '0;
      for (int p = 0; p < int'(N_READ_PORTS); p++) begin
         rd_data[p]  = r_data[rd_addr[p]];
         rd_ready[p] = r_ready[rd_addr[p]];
         if (BYPASS) begin
            for (int i = int'(N_WRITE_PORTS) - 1; i >= 0; i--) begin
               if (wr_en[i] && (wr_addr[i] == rd_addr[p])) begin
                  rd_data[p]  = wr_data[i];
                  rd_ready[p] = 1'b1;
               end
            end
         end
         if (is_zero(rd_addr[p])) begin
            rd_data[p]  = '0;
            rd_ready[p] = 1'b1;
         end
      end
   end

   assign n_not_ready = r_n_not_ready;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_aL) begin
         for (int k = 0; k < int'(N_ALLOC_PORTS); k++) begin
            if (alloc_en[k] && !is_zero(alloc_addr[k])) begin
               assert (r_ready[alloc_addr[k]]);
               for (int j = k + 1; j < int'(N_ALLOC_PORTS); j++) begin
                  assert (!(alloc_en[j] && (alloc_addr[j] == alloc_addr[k])));
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_prf_bypass.sv
// Self-checking bench for prf_bypass: directed scenarios plus randomized traffic
// compared against an array-based model, on a bypass and a non-bypass build.
`timescale 1ns/1ps
module tb_prf_bypass;
   localparam int W  = 32;
   localparam int N  = 64;
   localparam int NR = 4;
   localparam int NW = 2;
   localparam int NA = 2;
   localparam int PW = 6;

   logic clk = 1'b0;
   logic rst_aL;
   logic [NR-1:0][PW-1:0] rd_addr;
   logic [NR-1:0][W-1:0]  rd_data, rd_data_nb;
   logic [NR-1:0]         rd_ready, rd_ready_nb;
   logic [NW-1:0]         wr_en;
   logic [NW-1:0][PW-1:0] wr_addr;
   logic [NW-1:0][W-1:0]  wr_data;
   logic [NA-1:0]         alloc_en;
   logic [NA-1:0][PW-1:0] alloc_addr;
   logic [PW:0]           n_not_ready, n_not_ready_nb;

   logic [W-1:0] m_data [N];
   bit           m_ready [N];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prf_bypass u_dut (
      .clk(clk), .rst_aL(rst_aL), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
      .alloc_addr(alloc_addr), .n_not_ready(n_not_ready)
   );

   prf_bypass #(.BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .rst_aL(rst_aL), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_ready(rd_ready_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .n_not_ready(n_not_ready_nb)
   );

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int e = 0; e < N; e++) begin
         m_data[e]  = '0;
         m_ready[e] = 1'b1;
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int e = 0; e < N; e++) if (!m_ready[e]) c++;
      return c;
   endfunction

   task automatic model_commit();
      bit taken [N];
      for (int e = 0; e < N; e++) taken[e] = 1'b0;
      for (int i = 0; i < NW; i++) begin
         if (wr_en[i] && wr_addr[i] != 0 && !taken[wr_addr[i]]) begin
            taken[wr_addr[i]]   = 1'b1;
            m_data[wr_addr[i]]  = wr_data[i];
            m_ready[wr_addr[i]] = 1'b1;
         end
      end
      for (int k = 0; k < NA; k++) begin
         if (alloc_en[k] && alloc_addr[k] != 0) m_ready[alloc_addr[k]] = 1'b0;
      end
   endtask

   function automatic void exp_rd(input logic [PW-1:0] a, input bit byp,
                                  output logic [W-1:0] d, output logic r);
      d = m_data[a];
      r = m_ready[a];
      if (byp) begin
         for (int i = 0; i < NW; i++) begin
            if (wr_en[i] && wr_addr[i] == a) begin
               d = wr_data[i];
               r = 1'b1;
               break;
            end
         end
      end
      if (a == 0) begin
         d = '0;
         r = 1'b1;
      end
   endfunction

   task automatic idle();
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = '0;
      alloc_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rd_addr = '0;
      rst_aL  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < N; a += NR) begin
         for (int p = 0; p < NR; p++) rd_addr[p] = PW'(a + p);
         #1;
         for (int p = 0; p < NR; p++) begin
            n_cmp++;
            if (rd_data[p] !== '0 || rd_ready[p] !== 1'b1 ||
                rd_data_nb[p] !== '0 || rd_ready_nb[p] !== 1'b1) begin
               n_err++;
               $display("FAIL reset_rd addr=%0d got data=%h/%h rdy=%b/%b exp data=0 rdy=1",
                        a + p, rd_data[p], rd_data_nb[p], rd_ready[p], rd_ready_nb[p]);
            end
         end
      end
      n_cmp++;
      if (n_not_ready !== '0 || n_not_ready_nb !== '0) begin
         n_err++;
         $display("FAIL reset_count got %0d/%0d exp 0", n_not_ready, n_not_ready_nb);
      end
      @(negedge clk);
      rst_aL = 1'b1;
      step();
   endtask

   task automatic test_alloc_write();
      idle();
      alloc_en[0]   = 1'b1;
      alloc_addr[0] = 6'd5;
      rd_addr[0]    = 6'd5;
      #1;
      n_cmp++;
      if (rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL alloc_no_bypass got rdy=%b exp 1", rd_ready[0]);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_ready[0] !== 1'b0 || n_not_ready !== 7'd1) begin
         n_err++;
         $display("FAIL alloc5 got rdy=%b cnt=%0d exp rdy=0 cnt=1", rd_ready[0], n_not_ready);
      end
      wr_en[0]   = 1'b1;
      wr_addr[0] = 6'd5;
      wr_data[0] = 32'hDEADBEEF;
      #1;
      n_cmp++;
      if (rd_data[0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL wr5_bypass got %h/%b exp deadbeef/1", rd_data[0], rd_ready[0]);
      end
      n_cmp++;
      if (rd_data_nb[0] !== 32'h0 || rd_ready_nb[0] !== 1'b0) begin
         n_err++;
         $display("FAIL wr5_nobypass got %h/%b exp 0/0", rd_data_nb[0], rd_ready_nb[0]);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_data[0] !== 32'hDEADBEEF || rd_data_nb[0] !== 32'hDEADBEEF ||
          rd_ready[0] !== 1'b1 || n_not_ready !== 7'd0) begin
         n_err++;
         $display("FAIL wr5_stored got %h/%h rdy=%b cnt=%0d exp deadbeef rdy=1 cnt=0",
                  rd_data[0], rd_data_nb[0], rd_ready[0], n_not_ready);
      end
   endtask

   task automatic test_conflict();
      idle();
      wr_en      = 2'b11;
      wr_addr[0] = 6'd7;
      wr_data[0] = 32'h11;
      wr_addr[1] = 6'd7;
      wr_data[1] = 32'h22;
      rd_addr[1] = 6'd7;
      #1;
      n_cmp++;
      if (rd_data[1] !== 32'h11) begin
         n_err++;
         $display("FAIL conflict_bypass got %h exp 11", rd_data[1]);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_data[1] !== 32'h11 || rd_data_nb[1] !== 32'h11) begin
         n_err++;
         $display("FAIL conflict_stored got %h/%h exp 11", rd_data[1], rd_data_nb[1]);
      end
   endtask

   task automatic test_alloc_write_same();
      int c0;
      c0 = int'(n_not_ready);
      idle();
      alloc_en[0]   = 1'b1;
      alloc_addr[0] = 6'd9;
      wr_en[1]      = 1'b1;
      wr_addr[1]    = 6'd9;
      wr_data[1]    = 32'h55;
      rd_addr[2]    = 6'd9;
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_data[2] !== 32'h55 || rd_data_nb[2] !== 32'h55 ||
          rd_ready[2] !== 1'b0 || rd_ready_nb[2] !== 1'b0 || int'(n_not_ready) != c0 + 1) begin
         n_err++;
         $display("FAIL alloc_wr9 got %h/%h rdy=%b/%b cnt=%0d exp 55 rdy=0 cnt=%0d",
                  rd_data[2], rd_data_nb[2], rd_ready[2], rd_ready_nb[2], n_not_ready, c0 + 1);
      end
   endtask

   task automatic test_zero_reg();
      int c0;
      c0 = model_count();
      idle();
      wr_en[0]      = 1'b1;
      wr_addr[0]    = 6'd0;
      wr_data[0]    = 32'hFFFF;
      alloc_en[1]   = 1'b1;
      alloc_addr[1] = 6'd0;
      rd_addr[3]    = 6'd0;
      #1;
      n_cmp++;
      if (rd_data[3] !== 32'h0 || rd_ready[3] !== 1'b1) begin
         n_err++;
         $display("FAIL zero_bypass got %h/%b exp 0/1", rd_data[3], rd_ready[3]);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_data[3] !== 32'h0 || rd_data_nb[3] !== 32'h0 || rd_ready[3] !== 1'b1 ||
          rd_ready_nb[3] !== 1'b1 || int'(n_not_ready) != c0) begin
         n_err++;
         $display("FAIL zero_stored got %h/%h rdy=%b/%b cnt=%0d exp 0 rdy=1 cnt=%0d",
                  rd_data[3], rd_data_nb[3], rd_ready[3], rd_ready_nb[3], n_not_ready, c0);
      end
   endtask

   task automatic test_no_bypass();
      logic [W-1:0] old;
      old = m_data[3];
      idle();
      wr_en[0]   = 1'b1;
      wr_addr[0] = 6'd3;
      wr_data[0] = 32'hA5;
      rd_addr[0] = 6'd3;
      #1;
      n_cmp++;
      if (rd_data_nb[0] !== old || rd_data[0] !== 32'hA5) begin
         n_err++;
         $display("FAIL nobypass_same got nb=%h byp=%h exp nb=%h byp=a5",
                  rd_data_nb[0], rd_data[0], old);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rd_data_nb[0] !== 32'hA5) begin
         n_err++;
         $display("FAIL nobypass_next got %h exp a5", rd_data_nb[0]);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      alloc_en      = 2'b11;
      alloc_addr[0] = 6'd10;
      alloc_addr[1] = 6'd11;
      step();
      idle();
      wr_en[0]      = 1'b1;
      wr_addr[0]    = 6'd12;
      wr_data[0]    = 32'hCAFE;
      alloc_en[1]   = 1'b1;
      alloc_addr[1] = 6'd13;
      rd_addr[0]    = 6'd10;
      #2;
      rst_aL = 1'b0;
      #1;
      n_cmp++;
      if (n_not_ready !== '0 || rd_data[0] !== '0 || rd_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid got cnt=%0d data=%h rdy=%b exp 0/0/1",
                  n_not_ready, rd_data[0], rd_ready[0]);
      end
      model_reset();
      @(posedge clk);
      #1;
      idle();
      rd_addr[0] = 6'd12;
      rd_addr[1] = 6'd13;
      #1;
      n_cmp++;
      if (rd_data[0] !== '0 || rd_ready[1] !== 1'b1 || n_not_ready !== '0) begin
         n_err++;
         $display("FAIL reset_mid_lost got data=%h rdy=%b cnt=%0d exp 0/1/0",
                  rd_data[0], rd_ready[1], n_not_ready);
      end
      @(negedge clk);
      rst_aL = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [W-1:0] ed;
      logic         er;
      for (int c = 0; c < 400; c++) begin
         int span;
         span = ($urandom_range(0, 3) == 0) ? N - 1 : 15;
         for (int i = 0; i < NW; i++) begin
            wr_en[i]   = ($urandom_range(0, 9) < 6);
            wr_addr[i] = PW'($urandom_range(0, span));
            wr_data[i] = $urandom();
         end
         for (int k = 0; k < NA; k++) begin
            logic [PW-1:0] a;
            a = PW'($urandom_range(0, span));
            alloc_addr[k] = a;
            alloc_en[k]   = ($urandom_range(0, 9) < 4) && m_ready[a] &&
                            !(k == 1 && alloc_en[0] && alloc_addr[0] == a && a != 0);
         end
         for (int p = 0; p < NR; p++) begin
            rd_addr[p] = ($urandom_range(0, 2) == 0) ? wr_addr[$urandom_range(0, 1)]
                                                     : PW'($urandom_range(0, span));
         end
         #2;
         for (int p = 0; p < NR; p++) begin
            exp_rd(rd_addr[p], 1'b1, ed, er);
            n_cmp++;
            if (rd_data[p] !== ed || rd_ready[p] !== er) begin
               n_err++;
               $display("FAIL rand_byp cyc=%0d p=%0d addr=%0d got %h/%b exp %h/%b",
                        c, p, rd_addr[p], rd_data[p], rd_ready[p], ed, er);
            end
            exp_rd(rd_addr[p], 1'b0, ed, er);
            n_cmp++;
            if (rd_data_nb[p] !== ed || rd_ready_nb[p] !== er) begin
               n_err++;
               $display("FAIL rand_nobyp cyc=%0d p=%0d addr=%0d got %h/%b exp %h/%b",
                        c, p, rd_addr[p], rd_data_nb[p], rd_ready_nb[p], ed, er);
            end
         end
         n_cmp++;
         if (int'(n_not_ready) != model_count() || int'(n_not_ready_nb) != model_count()) begin
            n_err++;
            $display("FAIL rand_count cyc=%0d got %0d/%0d exp %0d",
                     c, n_not_ready, n_not_ready_nb, model_count());
         end
         step();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_alloc_write();
      test_conflict();
      test_alloc_write_same();
      test_zero_reg();
      test_no_bypass();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
